rubiks_movimentos_rx: RTL and testbench

//  Receives the solver's move list over the serial byte stream (host -> robot), the

---
 rtl/rubiks_movimentos_rx_pkg.sv | 37 +++
 rtl/rubiks_timeout_counter.sv | 29 ++
 rtl/rubiks_movimentos_rx.sv | 143 ++++++++++++++
 tb/tb_rubiks_movimentos_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rubiks_movimentos_rx_pkg.sv
// Shared definitions for the cube move link: frame constants, receiver state codes
// and the move-code layout (face*3 + turn) used by the transmitter and playback reader.
package rubiks_movimentos_rx_pkg;

    localparam logic [7:0] CAB_MOV      = 8'h4D;
    localparam logic [7:0] MOV_MAX_CODE = 8'd17;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ESPERA_CAB = 3'd1,
        CONTAGEM   = 3'd2,
        MOVS       = 3'd3,
        CHK        = 3'd4,
        OK         = 3'd5,
        ERRO       = 3'd6
    } estado_t;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_R = 3'd1,
        FACE_F = 3'd2,
        FACE_D = 3'd3,
        FACE_L = 3'd4,
        FACE_B = 3'd5
    } face_t;

    typedef enum logic [1:0] {
        TURN_CW  = 2'd0,
        TURN_CCW = 2'd1,
        TURN_180 = 2'd2
    } turn_t;

    function automatic logic [4:0] move_code(input face_t face, input turn_t turn);
        return 5'(face) * 5'd3 + 5'(turn);
    endfunction

endpackage

// File: rtl/rubiks_timeout_counter.sv
// Restartable down-counter: zera reloads TIMEOUT, conta counts down, fim flags
// that the full interval has elapsed while counting.
module rubiks_timeout_counter #(
    parameter int TIMEOUT = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] contador;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contador <= CW'(TIMEOUT);
        end else if (zera) begin
            contador <= CW'(TIMEOUT);
        end else if (conta && (contador != '0)) begin
            contador <= contador - CW'(1);
        end
    end

    assign fim = conta && (contador == '0);

endmodule

// File: rtl/rubiks_movimentos_rx.sv
// Receives the solver's move list frame (4D, N, moves, XOR checksum), writes the
// decoded move codes into the move memory and reports accept/reject to the control unit.
module rubiks_movimentos_rx
    import rubiks_movimentos_rx_pkg::*;
#(
    parameter int MAX_MOV = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              recebe,
    input  logic [7:0]        dado_rx,
    input  logic              dado_rx_pronto,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [4:0]        mem_dado,
    output logic [ADDR_W:0]   num_movimentos,
    output logic              movimentos_recebidos,
    output logic              erro,
    output logic [2:0]        db_estado
);

    estado_t           estado, estado_n;
    logic [ADDR_W:0]   indice, indice_n, indice_inc;
    logic [ADDR_W:0]   n_movs, n_movs_n;
    logic [7:0]        chk, chk_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [4:0]        mem_dado_n;
    logic [ADDR_W:0]   num_n;
    logic              em_quadro, fim_tempo, contagem_valida;

    assign em_quadro = (estado == CONTAGEM) || (estado == MOVS) || (estado == CHK);

    rubiks_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (dado_rx_pronto || !em_quadro),
        .conta (em_quadro),
        .fim   (fim_tempo)
    );

    assign indice_inc      = indice + {{ADDR_W{1'b0}}, 1'b1};
    assign contagem_valida = (dado_rx != 8'd0) && ({24'd0, dado_rx} <= 32'(MAX_MOV));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= OCIOSO;
            indice         <= '0;
            n_movs         <= '0;
            chk            <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_dado       <= '0;
            num_movimentos <= '0;
        end else begin
            estado         <= estado_n;
            indice         <= indice_n;
            n_movs         <= n_movs_n;
            chk            <= chk_n;
            mem_we         <= mem_we_n;
            mem_addr       <= mem_addr_n;
            mem_dado       <= mem_dado_n;
            num_movimentos <= num_n;
        end
    end

    // Dropping recebe outside OCIOSO aborts silently; a strobe takes priority over timeout.
    always_comb begin
        estado_n   = estado;
        indice_n   = indice;
        n_movs_n   = n_movs;
        chk_n      = chk;
        mem_we_n   = 1'b0;
        mem_addr_n = mem_addr;
        mem_dado_n = mem_dado;
        num_n      = num_movimentos;

        if (!recebe && (estado != OCIOSO)) begin
            estado_n = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (recebe) estado_n = ESPERA_CAB;
                end
                ESPERA_CAB: begin
                    if (dado_rx_pronto && (dado_rx == CAB_MOV)) estado_n = CONTAGEM;
                end
                CONTAGEM: begin
                    if (dado_rx_pronto) begin
                        if (contagem_valida) begin
                            estado_n = MOVS;
                            indice_n = '0;
                            chk_n    = dado_rx;
                            n_movs_n = dado_rx[ADDR_W:0];
                        end else begin
                            estado_n = ERRO;
                        end
                    end else if (fim_tempo) begin
                        estado_n = ERRO;
                    end
                end
                MOVS: begin
                    if (dado_rx_pronto) begin
                        if (dado_rx > MOV_MAX_CODE) begin
                            estado_n = ERRO;
                        end else begin
                            mem_we_n   = 1'b1;
                            mem_addr_n = indice[ADDR_W-1:0];
                            mem_dado_n = dado_rx[4:0];
                            chk_n      = chk ^ dado_rx;
                            indice_n   = indice_inc;
                            if (indice_inc == n_movs) estado_n = CHK;
                        end
                    end else if (fim_tempo) begin
                        estado_n = ERRO;
                    end
                end
                CHK: begin
                    if (dado_rx_pronto) begin
                        if (dado_rx == chk) begin
                            estado_n = OK;
                            num_n    = n_movs;
                        end else begin
                            estado_n = ERRO;
                        end
                    end else if (fim_tempo) begin
                        estado_n = ERRO;
                    end
                end
                OK:      estado_n = OK;
                ERRO:    estado_n = ESPERA_CAB;
                default: estado_n = OCIOSO;
            endcase
        end
    end

    assign movimentos_recebidos = (estado == OK);
    assign erro                 = (estado == ERRO);
    assign db_estado            = estado;

endmodule

// File: tb/tb_rubiks_movimentos_rx.sv
// Directed bench for the move-list receiver: valid frames, rejected frames,
// header hunting, timeout, abort, back-to-back full-size frame and reset.
module tb_rubiks_movimentos_rx;

    localparam int MAX_MOV = 64;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 200;

    logic              clock;
    logic              reset;
    logic              recebe;
    logic [7:0]        dado_rx;
    logic              dado_rx_pronto;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [4:0]        mem_dado;
    logic [ADDR_W:0]   num_movimentos;
    logic              movimentos_recebidos;
    logic              erro;
    logic [2:0]        db_estado;

    int checks = 0;
    int passes = 0;

    logic [7:0] tx_q[$];
    int         wr_addr[$];
    int         wr_data[$];
    int         erro_cycles = 0;

    rubiks_movimentos_rx #(
        .MAX_MOV(MAX_MOV),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .recebe              (recebe),
        .dado_rx             (dado_rx),
        .dado_rx_pronto      (dado_rx_pronto),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_dado            (mem_dado),
        .num_movimentos      (num_movimentos),
        .movimentos_recebidos(movimentos_recebidos),
        .erro                (erro),
        .db_estado           (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every memory write and erro cycle, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset && mem_we) begin
            wr_addr.push_back(int'(mem_addr));
            wr_data.push_back(int'(mem_dado));
        end
        if (reset && erro) erro_cycles++;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            dado_rx_pronto = 1'b0;
        end
    endtask

    task automatic send_tx(input bit b2b);
        for (int i = 0; i < tx_q.size(); i++) begin
            @(negedge clock);
            dado_rx        = tx_q[i];
            dado_rx_pronto = 1'b1;
            if (!b2b) begin
                @(negedge clock);
                dado_rx_pronto = 1'b0;
            end
        end
        idle(3);
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        erro_cycles = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; recebe = 1'b0; dado_rx = 8'h00; dado_rx_pronto = 1'b0;
        idle(3);
        checks++; if (db_estado !== 3'd0) $display("[TB] FAIL reset_state: got %0d, expected 0", db_estado); else passes++;
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_dado !== 5'd0)
            $display("[TB] FAIL reset_mem: got we=%b addr=%0d dado=%0d, expected all 0", mem_we, mem_addr, mem_dado); else passes++;
        checks++; if (num_movimentos !== '0) $display("[TB] FAIL reset_num: got %0d, expected 0", num_movimentos); else passes++;
        checks++; if (movimentos_recebidos !== 1'b0 || erro !== 1'b0)
            $display("[TB] FAIL reset_flags: got rec=%b erro=%b, expected 0 0", movimentos_recebidos, erro); else passes++;
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        checks++; if (db_estado !== 3'd0) $display("[TB] FAIL idle_without_recebe: got %0d, expected 0", db_estado); else passes++;
    endtask

    task automatic test_valid_frame();
        clear_logs();
        recebe = 1'b1;
        idle(2);
        checks++; if (db_estado !== 3'd1) $display("[TB] FAIL wait_header_state: got %0d, expected 1", db_estado); else passes++;
        tx_q = '{8'h4D, 8'h03, 8'h00, 8'h05, 8'h11, 8'h17};
        send_tx(1'b0);
        checks++; if (wr_addr.size() !== 3) $display("[TB] FAIL valid_write_count: got %0d, expected 3", wr_addr.size()); else passes++;
        if (wr_addr.size() == 3) begin
            checks++; if (wr_addr[0] !== 0 || wr_data[0] !== 0) $display("[TB] FAIL valid_write0: got (%0d,%0h), expected (0,0)", wr_addr[0], wr_data[0]); else passes++;
            checks++; if (wr_addr[1] !== 1 || wr_data[1] !== 5) $display("[TB] FAIL valid_write1: got (%0d,%0h), expected (1,5)", wr_addr[1], wr_data[1]); else passes++;
            checks++; if (wr_addr[2] !== 2 || wr_data[2] !== 17) $display("[TB] FAIL valid_write2: got (%0d,%0h), expected (2,11)", wr_addr[2], wr_data[2]); else passes++;
        end
        checks++; if (movimentos_recebidos !== 1'b1) $display("[TB] FAIL valid_accepted: got %b, expected 1", movimentos_recebidos); else passes++;
        checks++; if (num_movimentos !== 7'd3) $display("[TB] FAIL valid_num: got %0d, expected 3", num_movimentos); else passes++;
        checks++; if (erro_cycles !== 0) $display("[TB] FAIL valid_no_erro: got %0d erro cycles, expected 0", erro_cycles); else passes++;
        tx_q = '{8'h4D, 8'h01};
        send_tx(1'b0);
        checks++; if (db_estado !== 3'd5 || wr_addr.size() !== 3)
            $display("[TB] FAIL ok_discards_strobes: got state=%0d writes=%0d, expected 5 3", db_estado, wr_addr.size()); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(1);
        checks++; if (movimentos_recebidos !== 1'b0 || db_estado !== 3'd0)
            $display("[TB] FAIL ok_release: got rec=%b state=%0d, expected 0 0", movimentos_recebidos, db_estado); else passes++;
    endtask

    task automatic test_bad_checksum();
        clear_logs();
        recebe = 1'b1;
        idle(2);
        tx_q = '{8'h4D, 8'h03, 8'h00, 8'h05, 8'h11, 8'h16};
        send_tx(1'b0);
        checks++; if (erro_cycles !== 1) $display("[TB] FAIL badchk_erro_pulse: got %0d cycles, expected 1", erro_cycles); else passes++;
        checks++; if (movimentos_recebidos !== 1'b0) $display("[TB] FAIL badchk_not_accepted: got %b, expected 0", movimentos_recebidos); else passes++;
        checks++; if (db_estado !== 3'd1) $display("[TB] FAIL badchk_back_to_header: got %0d, expected 1", db_estado); else passes++;
        checks++; if (num_movimentos !== 7'd3) $display("[TB] FAIL badchk_num_kept: got %0d, expected 3", num_movimentos); else passes++;
        tx_q = '{8'h4D, 8'h02, 8'h07, 8'h08, 8'h0D};
        send_tx(1'b0);
        checks++; if (movimentos_recebidos !== 1'b1 || num_movimentos !== 7'd2)
            $display("[TB] FAIL resend_accepted: got rec=%b num=%0d, expected 1 2", movimentos_recebidos, num_movimentos); else passes++;
        checks++; if (erro_cycles !== 1) $display("[TB] FAIL resend_no_erro: got %0d cycles, expected 1", erro_cycles); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(1);
    endtask

    task automatic test_bad_frames();
        clear_logs();
        recebe = 1'b1;
        idle(2);
        tx_q = '{8'h4D, 8'h00};
        send_tx(1'b0);
        checks++; if (erro_cycles !== 1 || db_estado !== 3'd1)
            $display("[TB] FAIL count_zero: got erro=%0d state=%0d, expected 1 1", erro_cycles, db_estado); else passes++;
        tx_q = '{8'h4D, 8'h41};
        send_tx(1'b0);
        checks++; if (erro_cycles !== 2 || db_estado !== 3'd1)
            $display("[TB] FAIL count_over_max: got erro=%0d state=%0d, expected 2 1", erro_cycles, db_estado); else passes++;
        tx_q = '{8'h4D, 8'h02, 8'h05, 8'h12};
        send_tx(1'b0);
        checks++; if (erro_cycles !== 3 || db_estado !== 3'd1)
            $display("[TB] FAIL move_over_17: got erro=%0d state=%0d, expected 3 1", erro_cycles, db_estado); else passes++;
        checks++; if (num_movimentos !== 7'd2 || movimentos_recebidos !== 1'b0)
            $display("[TB] FAIL bad_frames_kept: got num=%0d rec=%b, expected 2 0", num_movimentos, movimentos_recebidos); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(1);
    endtask

    task automatic test_leading_garbage();
        clear_logs();
        recebe = 1'b1;
        idle(2);
        tx_q = '{8'h55, 8'hFF, 8'h4D, 8'h01, 8'h02, 8'h03};
        send_tx(1'b0);
        checks++; if (wr_addr.size() !== 1) $display("[TB] FAIL garbage_write_count: got %0d, expected 1", wr_addr.size()); else passes++;
        if (wr_addr.size() == 1) begin
            checks++; if (wr_addr[0] !== 0 || wr_data[0] !== 2) $display("[TB] FAIL garbage_write0: got (%0d,%0h), expected (0,2)", wr_addr[0], wr_data[0]); else passes++;
        end
        checks++; if (movimentos_recebidos !== 1'b1 || num_movimentos !== 7'd1 || erro_cycles !== 0)
            $display("[TB] FAIL garbage_accepted: got rec=%b num=%0d erro=%0d, expected 1 1 0", movimentos_recebidos, num_movimentos, erro_cycles); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(1);
    endtask

    task automatic test_timeout();
        int  wait_cycles;
        bit  seen;
        clear_logs();
        recebe = 1'b1;
        idle(2);
        @(negedge clock);
        dado_rx        = 8'h4D;
        dado_rx_pronto = 1'b1;
        seen        = 1'b0;
        wait_cycles = 0;
        for (int i = 1; i <= TIMEOUT + 20 && !seen; i++) begin
            @(negedge clock);
            dado_rx_pronto = 1'b0;
            if (erro) begin
                seen        = 1'b1;
                wait_cycles = i;
            end
        end
        checks++; if (!seen || wait_cycles < TIMEOUT || wait_cycles > TIMEOUT + 4)
            $display("[TB] FAIL timeout_erro: got seen=%0d after %0d cycles, expected near %0d", seen, wait_cycles, TIMEOUT); else passes++;
        idle(2);
        checks++; if (db_estado !== 3'd1) $display("[TB] FAIL timeout_back_to_header: got %0d, expected 1", db_estado); else passes++;
        clear_logs();
        tx_q = '{8'h4D, 8'h03, 8'h01};
        send_tx(1'b0);
        checks++; if (db_estado !== 3'd3) $display("[TB] FAIL abort_in_movs: got %0d, expected 3", db_estado); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(3);
        checks++; if (db_estado !== 3'd0 || erro_cycles !== 0)
            $display("[TB] FAIL abort_silent: got state=%0d erro=%0d, expected 0 0", db_estado, erro_cycles); else passes++;
        checks++; if (num_movimentos !== 7'd1 || movimentos_recebidos !== 1'b0)
            $display("[TB] FAIL abort_num_kept: got num=%0d rec=%b, expected 1 0", num_movimentos, movimentos_recebidos); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] chk;
        int         bad;
        clear_logs();
        recebe = 1'b1;
        idle(2);
        tx_q.delete();
        tx_q.push_back(8'h4D);
        tx_q.push_back(8'(MAX_MOV));
        chk = 8'(MAX_MOV);
        for (int i = 0; i < MAX_MOV; i++) begin
            tx_q.push_back(8'(i % 18));
            chk = chk ^ 8'(i % 18);
        end
        tx_q.push_back(chk);
        send_tx(1'b1);
        checks++; if (wr_addr.size() !== MAX_MOV) $display("[TB] FAIL b2b_write_count: got %0d, expected %0d", wr_addr.size(), MAX_MOV); else passes++;
        bad = 0;
        for (int i = 0; i < wr_addr.size() && i < MAX_MOV; i++) begin
            if (wr_addr[i] !== i || wr_data[i] !== (i % 18)) begin
                if (bad < 4) $display("[TB] FAIL b2b_write_%0d: got (%0d,%0d), expected (%0d,%0d)", i, wr_addr[i], wr_data[i], i, i % 18);
                bad++;
            end
        end
        checks++; if (bad != 0) $display("[TB] FAIL b2b_writes: got %0d wrong entries, expected 0", bad); else passes++;
        checks++; if (movimentos_recebidos !== 1'b1 || num_movimentos !== 7'(MAX_MOV))
            $display("[TB] FAIL b2b_accepted: got rec=%b num=%0d, expected 1 %0d", movimentos_recebidos, num_movimentos, MAX_MOV); else passes++;
        @(negedge clock);
        recebe = 1'b0;
        idle(1);
    endtask

    task automatic test_reset_mid_frame();
        recebe = 1'b1;
        idle(2);
        tx_q = '{8'h4D, 8'h02, 8'h03};
        send_tx(1'b0);
        #1 reset = 1'b0;
        #1;
        checks++; if (db_estado !== 3'd0 || num_movimentos !== '0)
            $display("[TB] FAIL midreset_state: got state=%0d num=%0d, expected 0 0", db_estado, num_movimentos); else passes++;
        checks++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_dado !== 5'd0 || erro !== 1'b0 || movimentos_recebidos !== 1'b0)
            $display("[TB] FAIL midreset_outputs: got we=%b addr=%0d dado=%0d erro=%b rec=%b, expected all 0",
                     mem_we, mem_addr, mem_dado, erro, movimentos_recebidos); else passes++;
        @(negedge clock);
        reset = 1'b1;
        idle(2);
        checks++; if (db_estado !== 3'd1) $display("[TB] FAIL after_reset_resume: got %0d, expected 1", db_estado); else passes++;
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_bad_frames();
        test_leading_garbage();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
